// File: rtl/vga_cursor_renderer.sv
// vga_cursor_renderer
//   VGA timing generator (640x480@60 by default) that draws a filled square
//   cursor over a solid background. The cursor position is sampled once per
//   frame, on entry to vertical blanking, so the drawn cursor never tears.
//   The timing geometry and the cursor reset position are parameters. Their
//   defaults give the standard 640x480 mode with the cursor centred.
//   Optional feature: define CURSOR_BLINK_EN to blink the cursor, toggling
//   every BLINK_FRAMES frames.
module vga_cursor_renderer #(
  parameter int          PIX_DIV      = 2,
  parameter int          CURSOR_SIZE  = 16,
  parameter logic [23:0] CURSOR_RGB   = 24'hFFFFFF,
  parameter logic [23:0] BG_RGB       = 24'h000080,
  parameter int          BLINK_FRAMES = 30,
  parameter int          H_VIS        = 640,
  parameter int          H_FP         = 16,
  parameter int          H_SYNC       = 96,
  parameter int          H_BP         = 48,
  parameter int          V_VIS        = 480,
  parameter int          V_FP         = 10,
  parameter int          V_SYNC       = 2,
  parameter int          V_BP         = 33,
  parameter int          CUR_X_RST    = 320,
  parameter int          CUR_Y_RST    = 240
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] cursor_x_pos,
  input  logic [10:0] cursor_y_pos,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_blank_n,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y
);

  localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

  localparam logic [9:0] H_LAST   = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] H_VIS_L  = 10'(H_VIS);
  localparam logic [9:0] HS_FIRST = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0] V_LAST   = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] V_VIS_L  = 10'(V_VIS);
  localparam logic [9:0] VS_FIRST = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_VIS + V_FP + V_SYNC - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             pix_en;
  logic [9:0]       h_cnt, v_cnt;
  logic [10:0]      cur_x, cur_y;
  logic             line_end, frame_end, vblank_entry;
  logic             visible, hit, cursor_vis;
  logic [11:0]      h12, v12, cx12, cy12, size12;

  assign pix_en       = (div_cnt == DIV_LAST);
  assign line_end     = pix_en && (h_cnt == H_LAST);
  assign frame_end    = line_end && (v_cnt == V_LAST);
  // Counters are about to step to (0, V_VIS): first blanking line.
  assign vblank_entry = line_end && (v_cnt == V_VIS_L - 10'd1);

  // Pixel-rate divider: one pix_en pulse every PIX_DIV clocks.
  always_ff @(posedge clk) begin
    if (reset || pix_en) div_cnt <= '0;
    else                 div_cnt <= div_cnt + DIV_W'(1);
  end

  // Raster counters, advanced once per pixel.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  // Cursor position is captured only on entry to vblank to avoid tearing.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_x <= 11'(CUR_X_RST);
      cur_y <= 11'(CUR_Y_RST);
    end else if (vblank_entry) begin
      cur_x <= cursor_x_pos;
      cur_y <= cursor_y_pos;
    end
  end

`ifdef CURSOR_BLINK_EN
  localparam logic [15:0] BLINK_LAST = 16'(BLINK_FRAMES - 1);
  logic [15:0] frame_cnt;
  logic        blink_on;

  // Frame counter toggles blink_on every BLINK_FRAMES frame wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (frame_end) begin
      if (frame_cnt == BLINK_LAST) begin
        frame_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

  assign cursor_vis = blink_on;
`else
  assign cursor_vis = 1'b1;
`endif

  // 12-bit compare so cur + CURSOR_SIZE cannot wrap; the cursor clips at
  // the right/bottom edges because those pixels are blanked anyway.
  assign h12    = {2'b00, h_cnt};
  assign v12    = {2'b00, v_cnt};
  assign cx12   = {1'b0, cur_x};
  assign cy12   = {1'b0, cur_y};
  assign size12 = 12'(CURSOR_SIZE);
  assign hit    = cursor_vis &&
                  (h12 >= cx12) && (h12 < cx12 + size12) &&
                  (v12 >= cy12) && (v12 < cy12 + size12);
  assign visible = (h_cnt < H_VIS_L) && (v_cnt < V_VIS_L);

  // Single output register stage: every output lags the counters by 1 clk.
  always_ff @(posedge clk) begin
    if (reset) begin
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
      {vga_r, vga_g, vga_b} <= 24'h0;
      pixel_x     <= '0;
      pixel_y     <= '0;
    end else begin
      vga_hs      <= !((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST));
      vga_vs      <= !((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST));
      vga_blank_n <= visible;
      if (!visible)  {vga_r, vga_g, vga_b} <= 24'h0;
      else if (hit)  {vga_r, vga_g, vga_b} <= CURSOR_RGB;
      else           {vga_r, vga_g, vga_b} <= BG_RGB;
      pixel_x     <= h_cnt;
      pixel_y     <= v_cnt;
    end
  end

  // frame_end only feeds the optional blink logic.
  logic unused_ok;
  assign unused_ok = frame_end;

endmodule

// File: tb/tb_vga_cursor_renderer.sv
// Bench for vga_cursor_renderer on a reduced raster (48x40 visible,
// 64x48 total) so that several whole frames fit in a short run.
// A model derives every output from the clock count since reset.
module tb_vga_cursor_renderer;
  localparam int D  = 2;
  localparam int S  = 8;
  localparam int HV = 48, HF = 4, HS = 8, HB = 4;
  localparam int VV = 40, VF = 2, VS = 2, VB = 4;
  localparam int RX = 24, RY = 20;
  localparam int BF = 2;
  localparam int HT = HV + HF + HS + HB;   // 64
  localparam int VT = VV + VF + VS + VB;   // 48
  localparam int FR = HT * VT;             // pixels per frame
  localparam int FCLK = FR * D;            // 6144 clk per frame
  localparam logic [23:0] CUR = 24'hFFFFFF;
  localparam logic [23:0] BG  = 24'h000080;

  logic clk = 1'b0, reset = 1'b1;
  logic [10:0] cursor_x_pos, cursor_y_pos;
  logic vga_hs, vga_vs, vga_blank_n;
  logic [7:0] vga_r, vga_g, vga_b;
  logic [9:0] pixel_x, pixel_y;

  int checks = 0, failures = 0;

  vga_cursor_renderer #(
    .PIX_DIV(D), .CURSOR_SIZE(S), .CURSOR_RGB(CUR), .BG_RGB(BG),
    .BLINK_FRAMES(BF),
    .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .CUR_X_RST(RX), .CUR_Y_RST(RY)
  ) dut (
    .clk(clk), .reset(reset),
    .cursor_x_pos(cursor_x_pos), .cursor_y_pos(cursor_y_pos),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .pixel_x(pixel_x), .pixel_y(pixel_y)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic hs, vs, bn;
    logic [23:0] rgb;
    logic [9:0] px, py;
  } out_t;

  // Outputs after an edge taken with k post-reset edges already elapsed.
  function automatic out_t pred(input int k, input int cx, input int cy);
    out_t o;
    int cnt, pos, h, v, frame;
    bit hit;
    cnt   = k / D;
    pos   = cnt % FR;
    h     = pos % HT;
    v     = pos / HT;
    frame = cnt / FR;
    hit   = (h >= cx) && (h < cx + S) && (v >= cy) && (v < cy + S);
`ifdef CURSOR_BLINK_EN
    if (((frame / BF) % 2) != 0) hit = 1'b0;
`else
    if (frame < 0) hit = 1'b0;
`endif
    o.hs  = !(h >= HV + HF && h < HV + HF + HS);
    o.vs  = !(v >= VV + VF && v < VV + VF + VS);
    o.bn  = (h < HV) && (v < VV);
    o.rgb = !o.bn ? 24'h0 : (hit ? CUR : BG);
    o.px  = 10'(h);
    o.py  = 10'(v);
    return o;
  endfunction

  int   k = 0, mcx = RX, mcy = RY;
  out_t exp_o;
  bit   exp_v = 1'b0;

  // Model: expected outputs for this edge, then the frame-boundary latch.
  always @(posedge clk) begin
    if (reset) begin
      k     <= 0;
      mcx   <= RX;
      mcy   <= RY;
      exp_o <= '{hs: 1'b1, vs: 1'b1, bn: 1'b0, rgb: 24'h0, px: 10'd0, py: 10'd0};
      exp_v <= 1'b1;
    end else begin
      exp_o <= pred(k, mcx, mcy);
      if (((k + 1) % D == 0) && (((k + 1) / D) % FR == VV * HT)) begin
        mcx <= int'(cursor_x_pos);
        mcy <= int'(cursor_y_pos);
      end
      k <= k + 1;
    end
  end

  // Cycle-by-cycle compare against the model.
  int nprint = 0;
  always @(negedge clk) begin
    if (exp_v) begin
      out_t act;
      act = '{hs: vga_hs, vs: vga_vs, bn: vga_blank_n,
              rgb: {vga_r, vga_g, vga_b}, px: pixel_x, py: pixel_y};
      checks++;
      if (act !== exp_o) begin
        failures++;
        if (nprint < 20)
          $display("FAIL model t=%0t got hs=%b vs=%b bn=%b rgb=%h x=%0d y=%0d need hs=%b vs=%b bn=%b rgb=%h x=%0d y=%0d",
                   $time, act.hs, act.vs, act.bn, act.rgb, act.px, act.py,
                   exp_o.hs, exp_o.vs, exp_o.bn, exp_o.rgb, exp_o.px, exp_o.py);
        nprint++;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s got %0h need %0h", name, act, req);
    end
  endtask

  // Wait for the output to show pixel (x,y); bounded by two frames.
  task automatic wait_px(input int x, input int y);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(int'(pixel_x) == x && int'(pixel_y) == y) && n < 2 * FCLK);
    if (n >= 2 * FCLK) begin
      checks++;
      failures++;
      $display("FAIL wait_px(%0d,%0d) timed out", x, y);
    end
  endtask

  task automatic px_rgb(input int x, input int y, input logic [23:0] req);
    wait_px(x, y);
    check($sformatf("rgb(%0d,%0d)", x, y), {8'h0, vga_r, vga_g, vga_b}, {8'h0, req});
  endtask

  function automatic logic sync_sig(input bit sel);
    return sel ? vga_vs : vga_hs;
  endfunction

  // Low time and period (in clk) of hs (sel=0) or vs (sel=1).
  task automatic measure(input bit sel, output int low, output int per);
    logic p, s;
    int n = 0;
    p = sync_sig(sel);
    forever begin
      @(negedge clk);
      s = sync_sig(sel);
      n++;
      if ((p && !s) || n > 3 * FCLK) break;
      p = s;
    end
    low = 0;
    per = 0;
    while (sync_sig(sel) == 1'b0 && per < 3 * FCLK) begin
      @(negedge clk); low++; per++;
    end
    while (sync_sig(sel) == 1'b1 && per < 3 * FCLK) begin
      @(negedge clk); per++;
    end
  endtask

  initial begin
    int low, per, hits;
    cursor_x_pos = 11'(RX);
    cursor_y_pos = 11'(RY);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_hs", {31'h0, vga_hs}, 32'd1);
    check("rst_vs", {31'h0, vga_vs}, 32'd1);
    check("rst_blank_n", {31'h0, vga_blank_n}, 32'd0);
    check("rst_rgb", {8'h0, vga_r, vga_g, vga_b}, 32'h0);
    reset = 1'b0;

`ifdef CURSOR_BLINK_EN
    // BLINK_FRAMES=2: on, on, off, off, on
    px_rgb(RX, RY, CUR);
    px_rgb(RX, RY, CUR);
    px_rgb(RX, RY, BG);
    px_rgb(RX, RY, BG);
    px_rgb(RX, RY, CUR);
`else
    // frame 0: default cursor at (24,20), 8x8
    px_rgb(23, 20, BG);
    px_rgb(24, 20, CUR);
    px_rgb(32, 20, BG);
    px_rgb(31, 27, CUR);
    px_rgb(24, 28, BG);
    wait_px(48, 28);
    check("blank_rgb", {8'h0, vga_r, vga_g, vga_b}, 32'h0);
    check("blank_n", {31'h0, vga_blank_n}, 32'd0);

    // sync timing: hs 8 px, line 64 px, vs 2 lines, frame 48 lines
    measure(1'b0, low, per);
    check("hs_low_clk", 32'(low), 32'd16);
    check("line_clk", 32'(per), 32'd128);
    measure(1'b1, low, per);
    check("vs_low_clk", 32'(low), 32'd256);
    check("frame_clk", 32'(per), 32'd6144);

    // mid-frame move in frame 2 has no effect until frame 3
    wait_px(0, 10);
    cursor_x_pos = 11'd5;
    cursor_y_pos = 11'd12;
    px_rgb(RX, RY, CUR);
    px_rgb(5, 12, CUR);
    px_rgb(RX, RY, BG);

    // clip at bottom-right corner, no wrap to (0,0)
    cursor_x_pos = 11'd44;
    cursor_y_pos = 11'd36;
    px_rgb(0, 0, BG);
    px_rgb(44, 36, CUR);
    px_rgb(47, 39, CUR);

    // x beyond visible width: no cursor pixels in the whole next frame
    cursor_x_pos = 11'd50;
    cursor_y_pos = 11'd10;
    wait_px(0, 0);
    hits = 0;
    for (int i = 0; i < FCLK; i++) begin
      if ({vga_r, vga_g, vga_b} == CUR) hits++;
      @(negedge clk);
    end
    check("offscreen_hits", 32'(hits), 32'd0);

    // reset mid-line restarts at (0,0) and restores default cursor
    wait_px(30, 30);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_px", {22'h0, pixel_x}, 32'd0);
    check("rst_py", {22'h0, pixel_y}, 32'd0);
    check("rst_bn", {31'h0, vga_blank_n}, 32'd1);
    px_rgb(RX, RY, CUR);
`endif
    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vga_cursor_renderer.md
Name: vga_cursor_renderer

Overview:
- Downstream consumer of the cursor controller's `cursor_x_pos` / `cursor_y_pos`.
- Generates 640x480@60 VGA timing from `clk` and draws a filled square cursor over a solid background.
- Captures the cursor position once per frame, at the start of vertical blanking, so the cursor never tears.
- Outputs drive the board VGA DAC directly.

Parameters:
- PIX_DIV, 2, clk cycles per pixel (50 MHz clk -> 25 MHz pixel rate); legal values >= 1.
- CURSOR_SIZE, 16, cursor square edge length in pixels.
- CURSOR_RGB, 24'hFFFFFF, cursor colour as {R,G,B}.
- BG_RGB, 24'h000080, background colour as {R,G,B}.
- BLINK_FRAMES, 30, frames per blink half-period (used only with the optional feature).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- cursor_x_pos  input  11  cursor top-left X, from the cursor controller
- cursor_y_pos  input  11  cursor top-left Y, from the cursor controller
- vga_hs  output  1  horizontal sync, active low
- vga_vs  output  1  vertical sync, active low
- vga_blank_n  output  1  high during the visible area
- vga_r  output  8  red
- vga_g  output  8  green
- vga_b  output  8  blue
- pixel_x  output  10  column of the current output pixel (0..799)
- pixel_y  output  10  row of the current output pixel (0..524)

Behaviour:
- Clock and reset: one clock, `clk`. `reset` is synchronous and active-high, sampled on the `clk` rising edge.
- Pixel divider:
  - `div_cnt` counts 0..PIX_DIV-1.
  - `pix_en` = (`div_cnt` == PIX_DIV-1).
  - h/v counters advance only on clk edges where `pix_en` = 1.
- Horizontal counter `h_cnt` 0..799:
  - Visible 0..639, front porch 640..655, sync 656..751, back porch 752..799.
  - Wraps 799 -> 0 and increments `v_cnt`.
- Vertical counter `v_cnt` 0..524:
  - Visible 0..479, front porch 480..489, sync 490..491, back porch 492..524.
  - Wraps 524 -> 0.
- Cursor latch:
  - On the `pix_en` edge where (`h_cnt`, `v_cnt`) transitions to (0, 480), register `cur_x` <= `cursor_x_pos` and `cur_y` <= `cursor_y_pos`.
  - Latched values hold for the entire following frame. Input changes at any other time have no visible effect until the next latch.
- Hit test, done in 12-bit unsigned arithmetic (no overflow):
  - hit = (`h_cnt` >= `cur_x`) && (`h_cnt` < `cur_x` + CURSOR_SIZE) && (`v_cnt` >= `cur_y`) && (`v_cnt` < `cur_y` + CURSOR_SIZE).
  - The cursor is clipped at the screen edges; it does not wrap to the opposite edge.
  - Out-of-range latched values (x >= 640 or y >= 480) produce no cursor pixels.
- Output stage: a single register stage. Every clk cycle, all outputs are computed from the current `h_cnt` / `v_cnt` / hit, so every output lags the counters by exactly 1 clk and all outputs are mutually aligned.
  - `vga_hs` = !(656 <= h <= 751).
  - `vga_vs` = !(490 <= v <= 491).
  - `vga_blank_n` = (h < 640 && v < 480).
  - RGB = 0 when blanked; otherwise CURSOR_RGB if hit (and visible), else BG_RGB.
  - `pixel_x` / `pixel_y` = h / v.
- Reset values:
  - `div_cnt` = 0, `h_cnt` = 0, `v_cnt` = 0.
  - `cur_x` = 320, `cur_y` = 240.
  - Outputs: `vga_hs` = 1, `vga_vs` = 1, `vga_blank_n` = 0, RGB = 0, `pixel_x` = 0, `pixel_y` = 0.
- Reset mid-frame: state is cleared in the same edge. Pixel (0,0) is emitted starting 1 clk after reset deasserts. No partial-frame latch is performed.
- Simultaneous latch and input change: the value present on the latch edge is the one captured.

Optional Feature:
- Macro: CURSOR_BLINK_EN.
- Defined:
  - A frame counter counts frame wraps (`v_cnt` 524 -> 0).
  - A `blink_on` flag toggles every BLINK_FRAMES frames. Reset values: `blink_on` = 1, frame counter = 0.
  - hit is additionally gated by `blink_on`.
  - `blink_on` changes only at the frame boundary.
- Undefined: no frame counter is present and the cursor is always visible.

Test Plan:
- Reset, PIX_DIV = 2: hold reset 3 clk -> outputs hs = 1, vs = 1, blank_n = 0, RGB = 0. After release: hs low for exactly 192 clk per line, line period 1600 clk, vs low for 3200 clk, frame period 840000 clk.
- Default cursor after reset: pixels (320,240) and (335,255) = FFFFFF; pixels (319,240), (336,240) and (320,256) = 000080; any pixel with h >= 640 = 0 with blank_n = 0.
- Mid-frame move: during v = 100, drive cursor to (10,20) -> cursor remains drawn at (320,240) for the rest of that frame; in the next frame, pixel (10,20) = FFFFFF and (320,240) = 000080.
- Edge clip: cursor (630,470) -> (639,479) = FFFFFF, (630,470) = FFFFFF, (0,0) = 000080 (no wrap); cursor (700,100) -> no FFFFFF pixel anywhere in the frame.
- Reset mid-line at h = 400, v = 300 -> first output after release is `pixel_x` = 0, `pixel_y` = 0; `cur_x` / `cur_y` return to 320/240.
- CURSOR_BLINK_EN, BLINK_FRAMES = 2: pixel (320,240) = FFFFFF in frames 0-1, 000080 in frames 2-3, FFFFFF in frame 4.
